// File: rtl/pwm_fade_sequencer_pkg.sv
// Shared types and helpers for the PWM fade sequencer: FSM state encoding,
// channel count and the duty-register address map.
package pwm_seq_pkg;

  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SCAN = 2'd2,
    ST_EMIT = 2'd3
  } seq_state_e;

  // Address of channel n's duty register. The base and stride come from the
  // instantiating module's parameters so every user shares one address map.
  function automatic logic [5:0] duty_addr(input logic [5:0] base,
                                           input logic [5:0] stride,
                                           input logic [1:0] n);
    duty_addr = base + (stride * {4'd0, n});
  endfunction

endpackage

// File: rtl/pwm_fade_sequencer_if.sv
// Peripheral write bus plus the direct host write port that shares it.
// The sequencer drives the peripheral side (master); the host/peripheral
// environment uses the slave view.
interface pwm_fade_sequencer_if;
  logic       i_host_we;
  logic [5:0] i_host_addr;
  logic [7:0] i_host_data;
  logic       o_write_en;
  logic [5:0] o_address;
  logic [7:0] o_data;

  modport master (
    input  i_host_we, i_host_addr, i_host_data,
    output o_write_en, o_address, o_data
  );

  modport slave (
    output i_host_we, i_host_addr, i_host_data,
    input  o_write_en, o_address, o_data
  );
endinterface

// File: rtl/pwm_fade_sequencer_step_calc.sv
// Combinational fade step: moves cur toward tgt by step (0 acts as 1),
// landing exactly on tgt instead of overshooting or wrapping.
module pwm_step_calc (
  input  logic [7:0] cur,
  input  logic [7:0] tgt,
  input  logic [7:0] step,
  output logic [7:0] next,
  output logic       differs
);

  logic [7:0] step_eff_s;
  logic [8:0] diff_s;
  logic [8:0] mag_s;

  // Signed 9-bit distance to the target and the saturating next value.
  always_comb begin
    if (step == 8'd0) begin
      step_eff_s = 8'd1;
    end else begin
      step_eff_s = step;
    end
    diff_s  = {1'b0, tgt} - {1'b0, cur};
    if (diff_s[8]) begin
      mag_s = 9'd0 - diff_s;
    end else begin
      mag_s = diff_s;
    end
    differs = (cur != tgt);
    if (mag_s <= {1'b0, step_eff_s}) begin
      next = tgt;
    end else if (diff_s[8]) begin
      next = cur - step_eff_s;
    end else begin
      next = cur + step_eff_s;
    end
  end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Three-channel PWM fade sequencer. Ramps each duty register toward its
// target once per fade tick and shares the peripheral write bus with a
// host port that always wins arbitration.
module pwm_fade_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int         TICK_DIV    = 256,
  parameter logic [5:0] DUTY_BASE   = 6'h01,
  parameter logic [5:0] ADDR_STRIDE = 6'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tgt_we,
  input  logic [1:0] i_tgt_chan,
  input  logic [7:0] i_tgt_value,
  input  logic [7:0] i_step,
  pwm_fade_sequencer_if.master bus,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [16:0] TICK_LAST = 17'(TICK_DIV - 1);
  localparam logic [1:0]  LAST_CH   = 2'(NUM_CH - 1);

  seq_state_e  state_r, state_s, adv_state_s;
  logic [16:0] presc_r, presc_s;
  logic [1:0]  ch_r, ch_s, adv_ch_s;
  logic [7:0]  next_r, next_s;
  logic [7:0]  cur_r [NUM_CH];
  logic [7:0]  tgt_r [NUM_CH];
  logic [7:0]  cur_s [NUM_CH];
  logic [7:0]  tgt_s [NUM_CH];
  logic [NUM_CH-1:0] host_hit_s;
  logic        hit_cur_s;
  logic        emit_grant_s;
  logic        any_diff_now_s;
  logic        any_diff_next_s;
  logic        done_s;
  logic [7:0]  calc_cur_s, calc_tgt_s, calc_next_s;
  logic        calc_differs_s;

  logic        write_en_r;
  logic [5:0]  address_r;
  logic [7:0]  data_r;
  logic        busy_r;
  logic        done_r;

  pwm_step_calc u_step_calc (
    .cur     (calc_cur_s),
    .tgt     (calc_tgt_s),
    .step    (i_step),
    .next    (calc_next_s),
    .differs (calc_differs_s)
  );

  // Host duty-address decode and sequencer bus grant.
  always_comb begin
    host_hit_s = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      host_hit_s[n] = bus.i_host_we &&
                      (bus.i_host_addr == duty_addr(DUTY_BASE, ADDR_STRIDE, 2'(n)));
    end
    emit_grant_s = (state_r == ST_EMIT) && !bus.i_host_we;
  end

  // Select the channel currently being scanned or emitted.
  always_comb begin
    case (ch_r)
      2'd0: begin
        calc_cur_s = cur_r[0];
        calc_tgt_s = tgt_r[0];
        hit_cur_s  = host_hit_s[0];
      end
      2'd1: begin
        calc_cur_s = cur_r[1];
        calc_tgt_s = tgt_r[1];
        hit_cur_s  = host_hit_s[1];
      end
      2'd2: begin
        calc_cur_s = cur_r[2];
        calc_tgt_s = tgt_r[2];
        hit_cur_s  = host_hit_s[2];
      end
      default: begin
        calc_cur_s = 8'd0;
        calc_tgt_s = 8'd0;
        hit_cur_s  = 1'b0;
      end
    endcase
  end

  // Next cur/tgt: a host duty write overrides everything on its channel,
  // otherwise target loads and granted emits update independently.
  always_comb begin
    any_diff_now_s  = 1'b0;
    any_diff_next_s = 1'b0;
    for (int n = 0; n < NUM_CH; n++) begin
      cur_s[n] = cur_r[n];
      tgt_s[n] = tgt_r[n];
      if (host_hit_s[n]) begin
        cur_s[n] = bus.i_host_data;
        tgt_s[n] = bus.i_host_data;
      end else begin
        if (i_tgt_we && (i_tgt_chan == 2'(n))) begin
          tgt_s[n] = i_tgt_value;
        end else begin
          tgt_s[n] = tgt_r[n];
        end
        if (emit_grant_s && (ch_r == 2'(n))) begin
          cur_s[n] = next_r;
        end else begin
          cur_s[n] = cur_r[n];
        end
      end
      any_diff_now_s  = any_diff_now_s  | (cur_r[n] != tgt_r[n]);
      any_diff_next_s = any_diff_next_s | (cur_s[n] != tgt_s[n]);
    end
  end

  // Sequencer FSM next-state: tick wait, per-channel scan, emit with stall.
  always_comb begin
    state_s = state_r;
    presc_s = presc_r;
    ch_s    = ch_r;
    next_s  = next_r;
    // Where the scan goes after finishing the current channel; the final
    // decision looks at this cycle's updates so a just-completed fade counts.
    if (ch_r == LAST_CH) begin
      adv_ch_s = 2'd0;
      if (any_diff_next_s) begin
        adv_state_s = ST_WAIT;
      end else begin
        adv_state_s = ST_IDLE;
      end
    end else begin
      adv_ch_s    = ch_r + 2'd1;
      adv_state_s = ST_SCAN;
    end
    case (state_r)
      ST_IDLE: begin
        if (any_diff_now_s) begin
          state_s = ST_WAIT;
          presc_s = 17'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (presc_r == TICK_LAST) begin
          state_s = ST_SCAN;
          ch_s    = 2'd0;
          presc_s = 17'd0;
        end else begin
          presc_s = presc_r + 17'd1;
        end
      end
      ST_SCAN: begin
        if (calc_differs_s && !hit_cur_s) begin
          next_s  = calc_next_s;
          state_s = ST_EMIT;
        end else begin
          state_s = adv_state_s;
          ch_s    = adv_ch_s;
          presc_s = 17'd0;
        end
      end
      ST_EMIT: begin
        // Granted, or dropped because the host just rewrote this channel.
        if (emit_grant_s || hit_cur_s) begin
          state_s = adv_state_s;
          ch_s    = adv_ch_s;
          presc_s = 17'd0;
        end else begin
          state_s = ST_EMIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    done_s = (state_r != ST_IDLE) && (state_s == ST_IDLE);
  end

  // FSM, prescaler and channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      presc_r <= 17'd0;
      ch_r    <= 2'd0;
      next_r  <= 8'd0;
      for (int n = 0; n < NUM_CH; n++) begin
        cur_r[n] <= 8'd0;
        tgt_r[n] <= 8'd0;
      end
    end else begin
      state_r <= state_s;
      presc_r <= presc_s;
      ch_r    <= ch_s;
      next_r  <= next_s;
      for (int n = 0; n < NUM_CH; n++) begin
        cur_r[n] <= cur_s[n];
        tgt_r[n] <= tgt_s[n];
      end
    end
  end

  // Registered bus and status outputs; host traffic has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en_r <= 1'b0;
      address_r  <= 6'd0;
      data_r     <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      if (bus.i_host_we) begin
        write_en_r <= 1'b1;
        address_r  <= bus.i_host_addr;
        data_r     <= bus.i_host_data;
      end else if (emit_grant_s) begin
        write_en_r <= 1'b1;
        address_r  <= duty_addr(DUTY_BASE, ADDR_STRIDE, ch_r);
        data_r     <= next_r;
      end else begin
        write_en_r <= 1'b0;
      end
      busy_r <= any_diff_now_s;
      done_r <= done_s;
    end
  end

  assign bus.o_write_en = write_en_r;
  assign bus.o_address  = address_r;
  assign bus.o_data     = data_r;
  assign o_busy         = busy_r;
  assign o_done         = done_r;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed bench for pwm_fade_sequencer: host pass-through vectors, a table
// of fade scenarios with hand-computed write sequences, and hand-written
// sequences for arbitration, abort and asynchronous reset.
module tb_pwm_fade_sequencer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_tgt_we = 1'b0;
  logic [1:0] i_tgt_chan = 2'd0;
  logic [7:0] i_tgt_value = 8'd0;
  logic [7:0] i_step = 8'd0;
  logic       o_busy;
  logic       o_done;

  pwm_fade_sequencer_if bus_if();

  pwm_fade_sequencer #(
    .TICK_DIV    (TD),
    .DUTY_BASE   (6'h01),
    .ADDR_STRIDE (6'h04)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_tgt_we    (i_tgt_we),
    .i_tgt_chan  (i_tgt_chan),
    .i_tgt_value (i_tgt_value),
    .i_step      (i_step),
    .bus         (bus_if),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [5:0] addr;
    logic [7:0] data;
    logic       exp_we;
    logic [5:0] exp_addr;
    logic [7:0] exp_data;
  } host_vec_t;

  typedef struct {
    logic [1:0]      chan;
    logic [7:0]      preset;
    logic [7:0]      tgt;
    logic [7:0]      step;
    int              n;
    logic [3:0][7:0] d;
  } fade_vec_t;

  host_vec_t hv [7];
  fade_vec_t fv [7];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] wd [16];
  logic [5:0] wa [16];
  int         wc [16];
  int         wn;
  bit         got_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] chan_addr(input logic [1:0] c);
    case (c)
      2'd0:    chan_addr = 6'h01;
      2'd1:    chan_addr = 6'h05;
      2'd2:    chan_addr = 6'h09;
      default: chan_addr = 6'h3f;
    endcase
  endfunction

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    bus_if.i_host_we   = 1'b1;
    bus_if.i_host_addr = a;
    bus_if.i_host_data = d;
    step_clk();
    bus_if.i_host_we   = 1'b0;
  endtask

  task automatic load_tgt(input logic [1:0] c, input logic [7:0] v);
    i_tgt_we    = 1'b1;
    i_tgt_chan  = c;
    i_tgt_value = v;
    step_clk();
    i_tgt_we    = 1'b0;
  endtask

  // Records every strobe until o_done or the cycle budget runs out.
  task automatic collect(input int budget);
    wn = 0;
    got_done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step_clk();
      if (bus_if.o_write_en) begin
        if (wn < 16) begin
          wd[wn] = bus_if.o_data;
          wa[wn] = bus_if.o_address;
          wc[wn] = i;
        end
        wn++;
      end
      if (o_done) begin
        got_done = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_write(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step_clk();
      if (bus_if.o_write_en) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int cnt;
    int dcnt;

    hv[0] = '{1'b1, 6'h30, 8'haa, 1'b1, 6'h30, 8'haa};
    hv[1] = '{1'b1, 6'h3f, 8'h55, 1'b1, 6'h3f, 8'h55};
    hv[2] = '{1'b1, 6'h00, 8'h01, 1'b1, 6'h00, 8'h01};
    hv[3] = '{1'b1, 6'h0d, 8'h77, 1'b1, 6'h0d, 8'h77};
    hv[4] = '{1'b0, 6'h12, 8'h34, 1'b0, 6'h00, 8'h00};
    hv[5] = '{1'b1, 6'h02, 8'hc3, 1'b1, 6'h02, 8'hc3};
    hv[6] = '{1'b0, 6'h00, 8'h00, 1'b0, 6'h00, 8'h00};

    fv[0] = '{2'd0, 8'd0,   8'd64,  8'd16,  4, {8'd64, 8'd48, 8'd32, 8'd16}};
    fv[1] = '{2'd0, 8'd250, 8'd255, 8'd16,  1, {8'd0,  8'd0,  8'd0,  8'd255}};
    fv[2] = '{2'd1, 8'd10,  8'd0,   8'd4,   3, {8'd0,  8'd0,  8'd2,  8'd6}};
    fv[3] = '{2'd2, 8'd0,   8'd3,   8'd0,   3, {8'd0,  8'd3,  8'd2,  8'd1}};
    fv[4] = '{2'd2, 8'd200, 8'd100, 8'd60,  2, {8'd0,  8'd0,  8'd100, 8'd140}};
    fv[5] = '{2'd0, 8'd0,   8'd255, 8'd255, 1, {8'd0,  8'd0,  8'd0,  8'd255}};
    fv[6] = '{2'd1, 8'd255, 8'd0,   8'd200, 2, {8'd0,  8'd0,  8'd0,  8'd55}};

    bus_if.i_host_we   = 1'b0;
    bus_if.i_host_addr = 6'd0;
    bus_if.i_host_data = 8'd0;

    // Reset state.
    #1;
    check("rst_write_en", 32'(bus_if.o_write_en), 32'd0);
    check("rst_address",  32'(bus_if.o_address),  32'd0);
    check("rst_data",     32'(bus_if.o_data),     32'd0);
    check("rst_busy",     32'(o_busy),            32'd0);
    check("rst_done",     32'(o_done),            32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step_clk();

    // Host pass-through, back to back, one cycle latency.
    for (int i = 0; i < 7; i++) begin
      bus_if.i_host_we   = hv[i].we;
      bus_if.i_host_addr = hv[i].addr;
      bus_if.i_host_data = hv[i].data;
      step_clk();
      check($sformatf("host%0d_we", i), 32'(bus_if.o_write_en), 32'(hv[i].exp_we));
      if (hv[i].exp_we) begin
        check($sformatf("host%0d_addr", i), 32'(bus_if.o_address), 32'(hv[i].exp_addr));
        check($sformatf("host%0d_data", i), 32'(bus_if.o_data),    32'(hv[i].exp_data));
      end
    end
    bus_if.i_host_we = 1'b0;
    repeat (3) step_clk();
    check("host_no_busy", 32'(o_busy), 32'd0);

    // Fade scenarios.
    for (int v = 0; v < 7; v++) begin
      host_write(chan_addr(fv[v].chan), fv[v].preset);
      repeat (3) step_clk();
      i_step = fv[v].step;
      load_tgt(fv[v].chan, fv[v].tgt);
      collect(300);
      check($sformatf("fade%0d_done_seen", v), 32'(got_done), 32'd1);
      check($sformatf("fade%0d_count", v), 32'(wn), 32'(fv[v].n));
      for (int i = 0; i < fv[v].n && i < wn; i++) begin
        check($sformatf("fade%0d_w%0d_addr", v, i), 32'(wa[i]), 32'(chan_addr(fv[v].chan)));
        check($sformatf("fade%0d_w%0d_data", v, i), 32'(wd[i]), 32'(fv[v].d[i]));
        if (i > 0) begin
          check($sformatf("fade%0d_w%0d_gap", v, i), 32'(wc[i] - wc[i-1] >= TD), 32'd1);
        end
      end
      step_clk();
      check($sformatf("fade%0d_done_width", v), 32'(o_done), 32'd0);
      check($sformatf("fade%0d_busy_low", v),   32'(o_busy), 32'd0);
    end

    // Target load on channel 3 is ignored.
    i_step = 8'd16;
    load_tgt(2'd3, 8'd99);
    collect(30);
    check("ch3_no_writes", 32'(wn), 32'd0);
    check("ch3_no_done",   32'(got_done), 32'd0);
    check("ch3_no_busy",   32'(o_busy), 32'd0);

    // Arbitration: host holds the bus over a pending emit.
    host_write(6'h01, 8'd0);
    repeat (3) step_clk();
    i_step = 8'd16;
    load_tgt(2'd0, 8'd32);
    for (int k = 0; k < 12; k++) begin
      bus_if.i_host_we   = 1'b1;
      bus_if.i_host_addr = 6'h30;
      bus_if.i_host_data = 8'(8'h40 + k);
      step_clk();
      check($sformatf("arb_hold%0d_we", k),   32'(bus_if.o_write_en), 32'd1);
      check($sformatf("arb_hold%0d_addr", k), 32'(bus_if.o_address),  32'h30);
      check($sformatf("arb_hold%0d_data", k), 32'(bus_if.o_data),     32'(8'h40 + k));
    end
    bus_if.i_host_we = 1'b0;
    step_clk();
    check("arb_seq_we",   32'(bus_if.o_write_en), 32'd1);
    check("arb_seq_addr", 32'(bus_if.o_address),  32'h01);
    check("arb_seq_data", 32'(bus_if.o_data),     32'd16);
    collect(100);
    check("arb_drain_done",  32'(got_done), 32'd1);
    check("arb_drain_count", 32'(wn), 32'd1);
    if (wn >= 1) begin
      check("arb_drain_data", 32'(wd[0]), 32'd32);
    end

    // Abort: host rewrites ch1 mid-fade.
    host_write(6'h05, 8'd0);
    repeat (3) step_clk();
    i_step = 8'd10;
    load_tgt(2'd1, 8'd200);
    wait_write(50, found);
    check("abort_first_seen", 32'(found), 32'd1);
    check("abort_first_data", 32'(bus_if.o_data), 32'd10);
    bus_if.i_host_we   = 1'b1;
    bus_if.i_host_addr = 6'h05;
    bus_if.i_host_data = 8'd80;
    step_clk();
    bus_if.i_host_we   = 1'b0;
    wn = 0;
    got_done = o_done;
    if (bus_if.o_write_en) begin
      wd[0] = bus_if.o_data;
      wa[0] = bus_if.o_address;
      wn = 1;
    end
    if (!got_done) begin
      cnt = wn;
      collect(100);
      if (cnt == 1) begin
        wd[wn < 16 ? wn : 15] = wd[0];
      end
      wn = wn + cnt;
    end
    check("abort_done",        32'(got_done), 32'd1);
    check("abort_strobes",     32'(wn), 32'd1);
    check("abort_host_addr",   32'(wa[0]), 32'h05);
    check("abort_host_data",   32'(wd[0]), 32'd80);
    step_clk();
    check("abort_busy_low", 32'(o_busy), 32'd0);

    // Asynchronous reset in the middle of a ramp.
    host_write(6'h01, 8'd0);
    repeat (3) step_clk();
    i_step = 8'd16;
    load_tgt(2'd0, 8'd64);
    wait_write(50, found);
    check("rstmid_first_seen", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_write_en", 32'(bus_if.o_write_en), 32'd0);
    check("rstmid_address",  32'(bus_if.o_address),  32'd0);
    check("rstmid_data",     32'(bus_if.o_data),     32'd0);
    check("rstmid_busy",     32'(o_busy),            32'd0);
    check("rstmid_done",     32'(o_done),            32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    cnt  = 0;
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      step_clk();
      if (bus_if.o_write_en) cnt++;
      if (o_done) dcnt++;
    end
    check("rstmid_no_writes", 32'(cnt), 32'd0);
    check("rstmid_no_done",   32'(dcnt), 32'd0);
    check("rstmid_busy_low",  32'(o_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_fade_sequencer.md
# pwm_fade_sequencer

Register-bus master for the three-channel PWM peripheral. It ramps each channel's duty register from its current value toward a programmed target in fixed steps at a programmable tick rate. It also arbitrates the peripheral's write bus between itself and a direct host write port. It sits between the top-level host pins and the peripheral's `write_en`/`address`/`data` inputs.

## Interface
Parameters:
- `TICK_DIV`, 256: clock cycles per fade tick, from 2 to 65536.
- `DUTY_BASE`, 6'h01: address of the channel 0 duty register.
- `ADDR_STRIDE`, 6'h04: address distance between channel duty registers. Channel n is at `DUTY_BASE + n*ADDR_STRIDE`, with n = 0..2.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_tgt_we` in 1: load a fade target.
- `i_tgt_chan` in 2: channel for the target load. Value 3 is ignored.
- `i_tgt_value` in 8: target duty.
- `i_step` in 8: duty increment per tick. A value of 0 is treated as 1. Sampled at every update.
- `i_host_we` in 1: direct host write request.
- `i_host_addr` in 6: host write address.
- `i_host_data` in 8: host write data.
- `o_write_en` in→out 1: peripheral write strobe.
- `o_address` out 6: peripheral address.
- `o_data` out 8: peripheral write data.
- `o_busy` out 1: high while any channel's current value differs from its target.
- `o_done` out 1: one-cycle pulse when the last fade finishes.

(`o_write_en` is an output.)

## Operation
- Per-channel state is `cur[n]` (8-bit) and `tgt[n]` (8-bit). Both are 0 after reset.
- FSM states are IDLE, WAIT, SCAN and EMIT.
  - IDLE → WAIT when any `cur != tgt`. The prescaler clears to 0 on this transition.
  - WAIT: the prescaler counts. At count `TICK_DIV-1` the FSM goes to SCAN with `ch = 0`.
  - SCAN(ch): if `cur[ch] != tgt[ch]`, compute `next`, then go to EMIT. Otherwise advance `ch`.
  - EMIT: perform the sequencer write and set `cur[ch] <= next`, then advance `ch`.
  - After ch 2, go to WAIT if any channel still differs. Otherwise go to IDLE and pulse `o_done`.
- Step arithmetic uses a 9-bit difference.
  - If `|tgt - cur| <= step`, then `next = tgt`.
  - Otherwise `next = cur ± step`, moving toward the target. The result never overshoots and never wraps.
- A target load sets `tgt[chan]` only. It takes effect at the next SCAN of that channel. Loading `tgt == cur` cancels that channel's fade.
- Arbitration: host writes have absolute priority.
  - When `i_host_we` is high, the bus carries the host transaction that cycle.
  - A sequencer write in EMIT stalls in EMIT, with `cur` not yet updated, until the bus is free.
- Host write to a duty address n:
  - Sets both `cur[n]` and `tgt[n]` to `i_host_data`, which aborts that channel's fade.
  - If EMIT is stalled on channel n, the pending write is dropped and `ch` advances.
- Host writes to other addresses pass through with no internal effect.
- Simultaneous events in the same cycle:
  - Host duty write and target load to the same channel: the host write wins.
  - Target load and EMIT on the same channel: EMIT uses the old `next`, and the new `tgt` applies next tick.

## Timing
- All outputs are registered. Reset values: `o_write_en=0`, `o_address=0`, `o_data=0`, `o_busy=0`, `o_done=0`.
- A host write appears on the bus exactly 1 cycle after `i_host_we`. Back-to-back host writes give back-to-back strobes.
- A sequencer write appears 1 cycle after EMIT is granted.
- Each strobe lasts one cycle and carries one address/data pair.
- A tick occurs every `TICK_DIV` cycles while in WAIT. SCAN and EMIT time does not stall the prescaler restart, which begins on re-entering WAIT.
- `o_busy` is a registered OR of `cur != tgt`, with 1-cycle lag.
- `o_done` is high for exactly one cycle on the transition into IDLE.
- Reset asserted mid-fade clears all state immediately. No partial write is emitted.

## Structure
- Package `pwm_seq_pkg` holds:
  - the FSM state enum;
  - the `NUM_CH=3` constant;
  - the address-computation function `duty_addr(n)`, which uses the module parameters.
- Sub-module `pwm_step_calc` is combinational. It takes `cur`, `tgt` and `step` and produces `next` and `differs`, with saturating behaviour.

## Test plan
- Ramp up: reset, `TICK_DIV=4`, `i_step=16`, target ch0=64 → four ch0 writes to addr 6'h01 with data 16, 32, 48, 64. Writes are 4+ cycles apart. `o_done` pulses once and `o_busy` falls.
- Saturation: `cur=250` (via host write), target 255, step 16 → exactly one write, data 255. Down-ramp from 10 to 0 with step 4 → 6, 2, 0.
- Step 0: target ch2=3, `i_step=0` → writes 1, 2, 3 at addr 6'h09.
- Arbitration: hold `i_host_we` with addr 6'h30 across a pending EMIT → host strobes only. The sequencer write follows on the first free cycle with unchanged data.
- Abort: ch1 fading 0→200; host writes 6'h05 = 80 → no further ch1 writes, `o_busy` low, `o_done` pulses.
- Async reset mid-ramp → all outputs 0 within the reset cycle. With no target loads after release, there are no writes.
